clint_bus_bridge: RTL

Memory-mapped bus front end for the core-local interruptor register block. It accepts single-beat load/store requests from the core's data-bus interconnect and decodes byte addresses in the CLINT window into the 2-bit register index. It drives the CLINT register block's write-enable, index and write data, and returns read data or an error through a valid/ready response channel. Partial-width stores are handled by read-modify-write.

---
 rtl/clint_pkg.sv | 35 +++
 rtl/clint_bus_bridge_if.sv | 30 +++
 rtl/clint_addr_decode.sv | 41 ++++
 rtl/clint_bus_bridge.sv | 120 ++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared types and constants for the CLINT bus bridge.
// CLINT_BRIDGE_WSTRB_EN adds the MERGE state for partial-strobe stores.
package clint_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROC  = 2'd1,
        RESP  = 2'd3
`ifdef CLINT_BRIDGE_WSTRB_EN
        ,
        MERGE = 2'd2
`endif
    } state_t;

    localparam logic [15:0] MSIP_OFF     = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

    localparam logic [1:0] IDX_MSIP     = 2'd0;
    localparam logic [1:0] IDX_MTIME    = 2'd1;
    localparam logic [1:0] IDX_MTIMECMP = 2'd2;

    function automatic logic [63:0] strb_merge(
        input logic [63:0] old_w,
        input logic [63:0] new_w,
        input logic [7:0]  strb
    );
        logic [63:0] m;
        m = old_w;
        for (int k = 0; k < 8; k++)
            if (strb[k]) m[8*k +: 8] = new_w[8*k +: 8];
        return m;
    endfunction

endpackage

// File: rtl/clint_bus_bridge_if.sv
// Single-beat request/response channel between the
// data-bus interconnect and the CLINT bridge.
interface clint_bus_bridge_if #(
    parameter int ADDR_W = 64
);
    logic              i_req_valid;
    logic              o_req_ready;
    logic              i_req_we;
    logic [ADDR_W-1:0] i_req_addr;
    logic [63:0]       i_req_wdata;
    logic [7:0]        i_req_wstrb;
    logic              o_rsp_valid;
    logic              i_rsp_ready;
    logic [63:0]       o_rsp_rdata;
    logic              o_rsp_err;

    modport master (
        output i_req_valid, i_req_we, i_req_addr,
        output i_req_wdata, i_req_wstrb, i_rsp_ready,
        input  o_req_ready, o_rsp_valid,
        input  o_rsp_rdata, o_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr,
        input  i_req_wdata, i_req_wstrb, i_rsp_ready,
        output o_req_ready, o_rsp_valid,
        output o_rsp_rdata, o_rsp_err
    );
endinterface

// File: rtl/clint_addr_decode.sv
// Byte address to CLINT register index; err on miss or misalignment.
module clint_addr_decode
    import clint_pkg::*;
#(
    parameter int                ADDR_W = 64,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [1:0]        idx,
    output logic              err
);
    logic [ADDR_W-1:0] off;
    logic              in_win;
    logic [15:0]       lo;

    // Addresses below BASE wrap to a huge offset and fall outside.
    assign off    = addr - BASE;
    assign in_win = ~|off[ADDR_W-1:16];
    assign lo     = off[15:0];

    always_comb begin
        idx = IDX_MSIP;
        err = 1'b1;
        unique case (1'b1)
            in_win && (lo == MSIP_OFF): begin
                idx = IDX_MSIP;
                err = 1'b0;
            end
            in_win && (lo == MTIMECMP_OFF): begin
                idx = IDX_MTIMECMP;
                err = 1'b0;
            end
            in_win && (lo == MTIME_OFF): begin
                idx = IDX_MTIME;
                err = 1'b0;
            end
            default: ;
        endcase
        if (|addr[2:0]) err = 1'b1;
    end
endmodule

// File: rtl/clint_bus_bridge.sv
// Bus front end for the CLINT register block.
// CLINT_BRIDGE_WSTRB_EN enables read-modify-write for partial strobes.
module clint_bus_bridge
    import clint_pkg::*;
#(
    parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
    parameter int          ADDR_W    = 64
) (
    input  logic              clk,
    input  logic              arstn,
    clint_bus_bridge_if.slave bus,
    output logic              o_clint_we,
    output logic [1:0]        o_clint_addr,
    output logic [63:0]       o_clint_wdata,
    input  logic [63:0]       i_clint_rdata
);
    state_t      state;
    logic        we_q;
    logic [1:0]  idx_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        err_q;
    logic        rsp_valid_q;
    logic [63:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [1:0]  dec_idx;
    logic        dec_err;
    logic        strb_err;

    clint_addr_decode #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE_ADDR[ADDR_W-1:0])
    ) u_dec (
        .addr (bus.i_req_addr),
        .idx  (dec_idx),
        .err  (dec_err)
    );

`ifdef CLINT_BRIDGE_WSTRB_EN
    assign strb_err = 1'b0;
`else
    assign strb_err = bus.i_req_we
                    && (bus.i_req_wstrb != 8'hFF)
                    && (bus.i_req_wstrb != 8'h00);
`endif

    assign bus.o_req_ready = arstn && (state == IDLE);
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_rsp_err   = rsp_err_q;
    assign o_clint_addr    = idx_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            idx_q         <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            err_q         <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            o_clint_we    <= 1'b0;
            o_clint_wdata <= '0;
        end else begin
            o_clint_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.i_req_valid) begin
                        we_q    <= bus.i_req_we;
                        idx_q   <= dec_idx;
                        wdata_q <= bus.i_req_wdata;
                        wstrb_q <= bus.i_req_wstrb;
                        err_q   <= dec_err | strb_err;
                        state   <= PROC;
                    end
                end
                PROC: begin
                    rsp_rdata_q <= '0;
                    rsp_err_q   <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                    if (err_q) begin
                        rsp_err_q <= 1'b1;
                    end else if (!we_q) begin
                        rsp_rdata_q <= i_clint_rdata;
                    end else if (wstrb_q == 8'hFF) begin
                        o_clint_we    <= 1'b1;
                        o_clint_wdata <= wdata_q;
                    end else if (wstrb_q != 8'h00) begin
`ifdef CLINT_BRIDGE_WSTRB_EN
                        // Merge against the value read this cycle.
                        o_clint_we    <= 1'b1;
                        o_clint_wdata <= strb_merge(i_clint_rdata,
                                                    wdata_q, wstrb_q);
                        rsp_valid_q   <= 1'b0;
                        state         <= MERGE;
`else
                        rsp_err_q <= 1'b1;
`endif
                    end
                end
`ifdef CLINT_BRIDGE_WSTRB_EN
                MERGE: begin
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
`endif
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
